// File: rtl/mod_sum_postproc.sv
// mod_sum_postproc: post-processing stage of a modular adder, M = 2^W - k.
// Recombines the half-sums and carries of the plain path (a+b) and the
// offset path (a+b+k), then selects the offset result whenever either path
// carries out of the top bit. Two-stage valid/ready pipeline.
// Optional feature: define MOD_POST_REDUCE_CNT_EN to build the saturating
// counter of delivered reduced results on reduce_cnt. Without the macro,
// reduce_cnt is tied to zero.
module mod_sum_postproc #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] h,
    input  logic [W-1:0] h_prim,
    input  logic [W-1:0] c,
    input  logic [W-1:0] c_prim,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         reduced,
    output logic [15:0]  reduce_cnt
);

    logic [W-1:0] s_plain;
    logic [W-1:0] s_offs;
    logic         sel;

    logic [W-1:0] s1_plain;
    logic [W-1:0] s1_offs;
    logic         s1_sel;
    logic         v1;
    logic         v2;

    logic         take2;
    logic         load1;
    logic         out_hs;

    // Sum bits from half-sums and the carry into each bit (carry into bit 0 is 0)
    always_comb begin
        s_plain = h      ^ {c[W-2:0], 1'b0};
        s_offs  = h_prim ^ {c_prim[W-2:0], 1'b0};
        sel     = c[W-1] | c_prim[W-1];
    end

    // Pipeline handshake: stage 2 takes from stage 1 when empty or draining
    always_comb begin
        take2     = v1 & (~v2 | out_ready);
        in_ready  = ~v1 | take2;
        load1     = in_valid & in_ready;
        out_valid = v2;
        out_hs    = v2 & out_ready;
    end

    // Stage 1: register both candidate sums and the selection bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1       <= 1'b0;
            s1_plain <= '0;
            s1_offs  <= '0;
            s1_sel   <= 1'b0;
        end else begin
            if (load1) begin
                v1       <= 1'b1;
                s1_plain <= s_plain;
                s1_offs  <= s_offs;
                s1_sel   <= sel;
            end else if (take2) begin
                v1 <= 1'b0;
            end
        end
    end

    // Stage 2: final mux into the output register; holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2      <= 1'b0;
            sum     <= '0;
            reduced <= 1'b0;
        end else begin
            if (take2) begin
                v2      <= 1'b1;
                sum     <= s1_sel ? s1_offs : s1_plain;
                reduced <= s1_sel;
            end else if (out_hs) begin
                v2 <= 1'b0;
            end
        end
    end

`ifdef MOD_POST_REDUCE_CNT_EN
    logic [15:0] cnt_q;

    // Count delivered reduced results, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_hs && reduced && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign reduce_cnt = cnt_q;
`else
    assign reduce_cnt = '0;
`endif

endmodule

// File: tb/tb_mod_sum_postproc.sv
// Directed self-checking bench for mod_sum_postproc, W=7, k=5 (M=123).
// Honours MOD_POST_REDUCE_CNT_EN for the expected reduce_cnt values.
module tb_mod_sum_postproc;

    localparam int W = 7;
    localparam int K = 5;
    localparam int M = 123;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] h, h_prim, c, c_prim;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         reduced;
    logic [15:0]  reduce_cnt;

    int tests = 0;
    int fails = 0;
    int rc    = 0;   // reduced results delivered since last reset

    mod_sum_postproc #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .h         (h),
        .h_prim    (h_prim),
        .c         (c),
        .c_prim    (c_prim),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .reduced   (reduced),
        .reduce_cnt(reduce_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] carries(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic         cy;
        cy = 1'b0;
        for (int i = 0; i < W; i++) begin
            r[i] = (x[i] & y[i]) | ((x[i] ^ y[i]) & cy);
            cy   = r[i];
        end
        return r;
    endfunction

    // Present operands a,b as derived half-sum/carry vectors; garbage when idle
    task automatic drive(input int a, input int b, input logic v);
        logic [W-1:0] xa, xb, xbp;
        in_valid = v;
        if (v) begin
            xa  = a[W-1:0];
            xb  = b[W-1:0];
            xbp = 7'(b + K);
            h      = xa ^ xb;
            c      = carries(xa, xb);
            h_prim = xa ^ xbp;
            c_prim = carries(xa, xbp);
        end else begin
            h      = 7'($urandom);
            c      = 7'($urandom);
            h_prim = 7'($urandom);
            c_prim = 7'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef MOD_POST_REDUCE_CNT_EN
        return (n > 65535) ? 65535 : n;
`else
        return 0 * n;
`endif
    endfunction

    int sa[4];
    int sb[4];
    int next_in, next_out;
    logic acc, ohs;
    int e;

    initial begin
        rst = 1'b1; out_ready = 1'b0;
        drive(0, 0, 1'b0);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_sum", 32'(sum), 0);
        check("rst_reduced", 32'(reduced), 0);
        check("rst_cnt", 32'(reduce_cnt), 0);
        tick(); tick();
        rst = 1'b0;

        // 100+30 = 130 -> 7, reduced; accepted on first edge after reset
        drive(100, 30, 1'b1);
        #1 check("t1_in_ready", 32'(in_ready), 1);
        tick();
        drive(0, 0, 1'b0);
        check("t1_lat1_valid", 32'(out_valid), 0);
        tick();
        check("t1_lat2_valid", 32'(out_valid), 1);
        check("t1_sum", 32'(sum), 7);
        check("t1_reduced", 32'(reduced), 1);
        tick();
        check("t1_hold_valid", 32'(out_valid), 1);
        check("t1_hold_sum", 32'(sum), 7);
        out_ready = 1'b1;
        tick(); rc++;
        check("t1_drained", 32'(out_valid), 0);
        check("t1_cnt", 32'(reduce_cnt), 32'(exp_cnt(rc)));

        // 10+20 = 30, not reduced
        drive(10, 20, 1'b1); tick();
        drive(0, 0, 1'b0); tick();
        check("t2_valid", 32'(out_valid), 1);
        check("t2_sum", 32'(sum), 30);
        check("t2_reduced", 32'(reduced), 0);
        tick();

        // 61+62 = 123 = M -> 0, reduced
        drive(61, 62, 1'b1); tick();
        drive(0, 0, 1'b0); tick();
        check("t3_valid", 32'(out_valid), 1);
        check("t3_sum", 32'(sum), 0);
        check("t3_reduced", 32'(reduced), 1);
        tick(); rc++;
        check("t3_cnt", 32'(reduce_cnt), 32'(exp_cnt(rc)));

        // 8 back-to-back words; result j-1 is visible after edge j
        for (int j = 0; j < 10; j++) begin
            if (j < 8) drive(j * 15 + 3, 100 - j * 7, 1'b1);
            else       drive(0, 0, 1'b0);
            #1 check("stream_in_ready", 32'(in_ready), 1);
            tick();
            if (j >= 1 && j <= 8) begin
                e = ((j - 1) * 15 + 3) + (100 - (j - 1) * 7);
                check("stream_valid", 32'(out_valid), 1);
                check("stream_sum", 32'(sum), 32'(e % M));
                check("stream_reduced", 32'(reduced), 32'(e >= M));
                if (e >= M) rc++;
            end else begin
                check("stream_idle", 32'(out_valid), 0);
            end
        end
        tick();
        check("stream_cnt", 32'(reduce_cnt), 32'(exp_cnt(rc)));

        // Backpressure: out_ready low for 5 cycles with in_valid high
        sa = '{50, 1, 70, 5};
        sb = '{80, 2, 60, 5};
        next_in = 0; next_out = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            out_ready = (cyc >= 5);
            if (next_in < 4) drive(sa[next_in], sb[next_in], 1'b1);
            else             drive(0, 0, 1'b0);
            #1;
            if (cyc == 2 || cyc == 4) begin
                check("bp_in_ready_low", 32'(in_ready), 0);
                check("bp_accepts", 32'(next_in), 2);
                check("bp_stable_valid", 32'(out_valid), 1);
                check("bp_stable_sum", 32'(sum), 7);
            end
            acc = in_valid & in_ready;
            ohs = out_valid & out_ready;
            if (ohs) begin
                if (next_out < 4) begin
                    e = sa[next_out] + sb[next_out];
                    check("bp_order_sum", 32'(sum), 32'(e % M));
                    if (e >= M) rc++;
                end else begin
                    check("bp_extra_word", 32'(next_out), 3);
                end
            end
            tick();
            if (acc) next_in++;
            if (ohs) next_out++;
        end
        check("bp_delivered", 32'(next_out), 4);
        check("bp_empty", 32'(out_valid), 0);
        check("bp_cnt", 32'(reduce_cnt), 32'(exp_cnt(rc)));

        // Reset with both stages full
        out_ready = 1'b0;
        drive(100, 30, 1'b1); tick();
        drive(100, 30, 1'b1); tick();
        drive(0, 0, 1'b0);
        check("full_before_rst", 32'(in_ready), 0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_cnt", 32'(reduce_cnt), 0);
        tick();
        rst = 1'b0; rc = 0;
        out_ready = 1'b1;
        tick(); tick();
        check("post_rst_discard", 32'(out_valid), 0);

        // Saturation: 65540 reduced results
        for (int n = 0; n < 65540; n++) begin
            drive(100, 30, 1'b1);
            tick();
        end
        drive(0, 0, 1'b0);
        tick(); tick(); tick();
        rc = 65540;
        check("sat_cnt", 32'(reduce_cnt), 32'(exp_cnt(rc)));
        check("sat_idle", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mod_sum_postproc.md
MOD_SUM_POSTPROC -- requirements
Module: mod_sum_postproc

Interface
REQ-001 SHALL have parameter W, default 7, the operand and sum width in bits.
REQ-002 SHALL have ports clk (input, 1 bit), the single clock, and rst (input, 1 bit), an asynchronous active-high reset.
REQ-003 SHALL have port in_valid (input, 1 bit): the input word is valid.
REQ-004 SHALL have port in_ready (output, 1 bit): the block accepts the input word this cycle.
REQ-005 SHALL have ports h and h_prim (input, W bits each): the bitwise half-sums of the plain path (a,b) and the offset path (a',b').
REQ-006 SHALL have ports c and c_prim (input, W bits each): c[i] is the carry out of bit i for the plain path and the offset path respectively.
REQ-007 SHALL have port out_valid (output, 1 bit): the result is valid.
REQ-008 SHALL have port out_ready (input, 1 bit): the downstream accepts the result.
REQ-009 SHALL have port sum (output, W bits): the modular sum (a+b) mod M, where M = 2^W - k.
REQ-010 SHALL have port reduced (output, 1 bit): 1 when the offset path was selected.
REQ-011 SHALL have port reduce_cnt (output, 16 bits): the count of reduced results delivered.

Function
REQ-012 SHALL compute s[i] = h[i] ^ c[i-1] and s'[i] = h_prim[i] ^ c_prim[i-1], with c[-1] = c_prim[-1] = 0.
REQ-013 SHALL set sel = c[W-1] | c_prim[W-1], output s' when sel=1 and s otherwise, and drive reduced = sel.
REQ-014 SHALL form a two-stage pipeline: stage 1 registers {s, s', sel} plus valid v1; stage 2 registers {sum, reduced} plus valid v2; out_valid = v2.
REQ-015 SHALL define take2 = v1 & (~v2 | out_ready) and in_ready = ~v1 | take2; stage 1 loads when in_valid & in_ready, and v1 clears when take2 fires with no new load.
REQ-016 SHALL clear v2 when out_valid & out_ready occurs without take2, and set v2 when take2 fires.
REQ-017 SHALL give a latency of exactly 2 cycles from input handshake to out_valid with no backpressure, sustaining 1 result per cycle.
REQ-018 SHALL hold sum, reduced and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL stall stage 1 while stage 2 is full and out_ready=0; in_ready then drops only if v1=1.
REQ-020 SHALL load a new result in the same cycle an output handshake occurs, with no bubble.
REQ-021 SHALL leave the registers unchanged while in_valid=0 and out_ready=0, and ignore data on h, h_prim, c and c_prim when in_valid=0.
REQ-022 SHALL increment reduce_cnt on each output handshake with reduced=1, saturating at 0xFFFF with no wrap.

Reset
REQ-023 SHALL, while rst=1, asynchronously force v1=0, v2=0, sum=0, reduced=0 and reduce_cnt=0.
REQ-024 SHALL drive in_ready=1 and out_valid=0 during reset.
REQ-025 SHALL discard any in-flight data when reset asserts mid-operation.
REQ-026 SHALL accept input on the first rising clk edge after rst deasserts.

Configuration
REQ-027 SHALL, with macro MOD_POST_REDUCE_CNT_EN defined, implement the reduce_cnt counter as in REQ-022.
REQ-028 SHALL, without MOD_POST_REDUCE_CNT_EN, keep the reduce_cnt port tied to 0, include no counter flops, and leave all other behaviour identical.

Verification
REQ-029 SHALL test W=7, k=5 (M=123), a=100, b=30, driving the derived h/c/h'/c' -> sum=7, reduced=1, out_valid exactly 2 cycles after the handshake.
REQ-030 SHALL test a=10, b=20 -> sum=30, reduced=0; and a=61, b=62 (sum exactly M) -> sum=0, reduced=1.
REQ-031 SHALL stream 8 back-to-back words with out_ready=1 -> 8 results in 8 consecutive cycles, in order.
REQ-032 SHALL hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready falls after 2 accepts, output is stable, and no word is lost or duplicated after release.
REQ-033 SHALL assert rst for 1 cycle with both stages full -> out_valid=0, in_ready=1 and reduce_cnt=0 immediately.
REQ-034 SHALL deliver 65540 reduced results with the macro defined -> reduce_cnt=0xFFFF; without the macro -> reduce_cnt=0.
